// File: rtl/tinysnn_pkg.sv
// Shared types and helpers for the spiking-neuron datapath blocks.
// The rate decoder's optional smoothing is selected with RATE_SMOOTH_EN.
package tinysnn_pkg;

    localparam int SPIKE_RATE_W        = 8;
    localparam int SPIKE_WINDOW_CYCLES = 256;

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } rate_out_state_t;

    // Saturating add clamped at 2^w-1; the caller narrows the result to its own width.
    function automatic logic [31:0] sat_inc(input logic [31:0] cnt,
                                            input logic [31:0] inc,
                                            input int unsigned w);
        logic [32:0] sum;
        logic [32:0] max_val;
        max_val = (33'd1 << w) - 33'd1;
        sum     = {1'b0, cnt} + {1'b0, inc};
        return (sum > max_val) ? max_val[31:0] : sum[31:0];
    endfunction

endpackage

// File: rtl/spike_edge_counter.sv
// Rising-edge counter over a window of enabled cycles; strobes win_end_o on the
// last enabled cycle of each window with that cycle's edge already folded into result_o.
module spike_edge_counter
    import tinysnn_pkg::*;
#(
    parameter int WINDOW_CYCLES = SPIKE_WINDOW_CYCLES,
    parameter int W             = SPIKE_RATE_W
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         en_i,
    input  logic         spike_i,
    output logic         win_end_o,
    output logic [W-1:0] result_o
);

    localparam int WCW = $clog2(WINDOW_CYCLES);
    localparam logic [WCW-1:0] WLAST = WCW'(WINDOW_CYCLES - 1);

    logic           spike_q;
    logic           edge_w;
    logic [WCW-1:0] wcnt_q, wcnt_d;
    logic [W-1:0]   scnt_q, scnt_d;
    logic [W-1:0]   scnt_inc;

    assign edge_w    = spike_i & ~spike_q;
    assign scnt_inc  = W'(sat_inc(32'(scnt_q), 32'(edge_w), W));
    assign win_end_o = en_i & (wcnt_q == WLAST);
    assign result_o  = scnt_inc;

    always_comb begin
        wcnt_d = wcnt_q;
        scnt_d = scnt_q;
        if (en_i) begin
            if (win_end_o) begin
                wcnt_d = '0;
                scnt_d = '0;
            end else begin
                wcnt_d = wcnt_q + WCW'(1);
                scnt_d = scnt_inc;
            end
        end
    end

    // spike_q tracks the line even while frozen, so an edge during en=0 is lost.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            spike_q <= 1'b0;
            wcnt_q  <= '0;
            scnt_q  <= '0;
        end else begin
            spike_q <= spike_i;
            wcnt_q  <= wcnt_d;
            scnt_q  <= scnt_d;
        end
    end

endmodule

// File: rtl/spike_rate_decoder.sv
// Spike-train rate decoder: window counts leave on a one-entry valid/ready register
// with a sticky overrun flag. Define RATE_SMOOTH_EN to output an EMA of window results.
module spike_rate_decoder
    import tinysnn_pkg::*;
#(
    parameter int WINDOW_CYCLES = SPIKE_WINDOW_CYCLES,
    parameter int W             = SPIKE_RATE_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         spike_in,
    input  logic         rate_ready,
    output logic [W-1:0] rate_data,
    output logic         rate_valid,
    output logic         overrun
);

    logic            win_end;
    logic [W-1:0]    result;
    logic [W-1:0]    load_val;
    rate_out_state_t state_q;
    logic [W-1:0]    rate_data_q;
    logic            rate_valid_q;
    logic            overrun_q;

    spike_edge_counter #(
        .WINDOW_CYCLES (WINDOW_CYCLES),
        .W             (W)
    ) u_counter (
        .clk_i     (clk),
        .reset_i   (reset),
        .en_i      (en),
        .spike_i   (spike_in),
        .win_end_o (win_end),
        .result_o  (result)
    );

`ifdef RATE_SMOOTH_EN
    logic [W-1:0]      avg_q, avg_d;
    logic signed [W:0] diff_w, step_w, sum_w;

    // The new average always lies between the old one and the result, so W bits suffice.
    assign diff_w   = $signed({1'b0, result}) - $signed({1'b0, avg_q});
    assign step_w   = diff_w >>> 2;
    assign sum_w    = $signed({1'b0, avg_q}) + step_w;
    assign avg_d    = sum_w[W-1:0];
    assign load_val = avg_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            avg_q <= '0;
        end else if (win_end) begin
            avg_q <= avg_d;
        end
    end
`else
    assign load_val = result;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= OUT_EMPTY;
            rate_data_q  <= '0;
            rate_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            case (state_q)
                OUT_EMPTY: begin
                    if (win_end) begin
                        state_q      <= OUT_FULL;
                        rate_data_q  <= load_val;
                        rate_valid_q <= 1'b1;
                    end
                end
                OUT_FULL: begin
                    if (win_end) begin
                        if (rate_ready) begin
                            rate_data_q <= load_val;
                        end else begin
                            overrun_q <= 1'b1;
                        end
                    end else if (rate_ready) begin
                        state_q      <= OUT_EMPTY;
                        rate_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q      <= OUT_EMPTY;
                    rate_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign rate_data  = rate_data_q;
    assign rate_valid = rate_valid_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Bench for spike_rate_decoder: two instances (W=8 and W=2) on one stimulus stream,
// compared every cycle against a window-level reference model.
module tb_spike_rate_decoder;

    localparam int WIN = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0;
    logic       spike_in = 1'b0;
    logic       rate_ready = 1'b1;
    logic [7:0] rd8;
    logic [1:0] rd2;
    logic       rv8, rv2, ov8, ov2;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    int m_cnt[2], m_ncyc[2], m_valid[2], m_data[2], m_ovr[2], m_avg[2];
    int m_max[2] = '{255, 3};
    int m_prev = 0;

    always #5 clk = ~clk;

    spike_rate_decoder #(.WINDOW_CYCLES(WIN), .W(8)) u_dut8 (
        .clk(clk), .reset(reset), .en(en), .spike_in(spike_in), .rate_ready(rate_ready),
        .rate_data(rd8), .rate_valid(rv8), .overrun(ov8)
    );

    spike_rate_decoder #(.WINDOW_CYCLES(WIN), .W(2)) u_dut2 (
        .clk(clk), .reset(reset), .en(en), .spike_in(spike_in), .rate_ready(rate_ready),
        .rate_data(rd2), .rate_valid(rv2), .overrun(ov2)
    );

    // Window-level model: count edges as an unbounded integer, clamp once at window end,
    // then offer the result to a one-slot buffer that either accepts or drops it.
    task automatic model_update(input bit r, input bit e, input bit s, input bit rdy);
        int edge_v;
        int res;
        bit endw;
        if (r) begin
            m_prev = 0;
            for (int i = 0; i < 2; i++) begin
                m_cnt[i] = 0; m_ncyc[i] = 0; m_valid[i] = 0;
                m_data[i] = 0; m_ovr[i] = 0; m_avg[i] = 0;
            end
            return;
        end
        edge_v = (s && m_prev == 0) ? 1 : 0;
        m_prev = s ? 1 : 0;
        for (int i = 0; i < 2; i++) begin
            endw = 1'b0;
            res  = 0;
            if (e) begin
                m_cnt[i] += edge_v;
                m_ncyc[i]++;
                if (m_ncyc[i] == WIN) begin
                    endw = 1'b1;
                    res = (m_cnt[i] > m_max[i]) ? m_max[i] : m_cnt[i];
                    m_cnt[i] = 0;
                    m_ncyc[i] = 0;
                end
            end
            if (endw) begin
`ifdef RATE_SMOOTH_EN
                m_avg[i] = m_avg[i] + ((res - m_avg[i]) >>> 2);
                res = m_avg[i];
`endif
                if (m_valid[i] == 0 || rdy) begin
                    m_valid[i] = 1;
                    m_data[i] = res;
                end else begin
                    m_ovr[i] = 1;
                end
            end else if (m_valid[i] != 0 && rdy) begin
                m_valid[i] = 0;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s cycle=%0d observed=%0d expected=%0d", tag, cyc, obs, exp_v);
        end
    endtask

    task automatic check_all();
        chk("valid_w8",   32'(rv8), 32'(m_valid[0]));
        chk("data_w8",    32'(rd8), 32'(m_data[0]));
        chk("overrun_w8", 32'(ov8), 32'(m_ovr[0]));
        chk("valid_w2",   32'(rv2), 32'(m_valid[1]));
        chk("data_w2",    32'(rd2), 32'(m_data[1]));
        chk("overrun_w2", 32'(ov2), 32'(m_ovr[1]));
    endtask

    task automatic step(input bit r, input bit e, input bit s, input bit rdy);
        reset = r; en = e; spike_in = s; rate_ready = rdy;
        @(posedge clk);
        model_update(r, e, s, rdy);
        cyc++;
        #1;
        check_all();
    endtask

    // One window with n single-cycle pulses at even offsets.
    task automatic pulse_window(input int n, input bit rdy);
        for (int c = 0; c < WIN; c++) begin
            step(1'b0, 1'b1, (c % 2 == 0) && (c / 2 < n), rdy);
        end
    endtask

    initial begin
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 1'b0, 1'b1);
        chk("reset_data", 32'(rd8), 32'd0);
        chk("reset_valid", 32'(rv8), 32'd0);

        // pulses every 2nd cycle from reset release
        for (int k = 1; k <= 17; k++) begin
            step(1'b0, 1'b1, (k % 2) == 1, 1'b1);
`ifndef RATE_SMOOTH_EN
            if (k == 16) begin
                chk("t1_data8", 32'(rd8), 32'd8);
                chk("t1_valid8", 32'(rv8), 32'd1);
                chk("t1_data2_sat", 32'(rd2), 32'd3);
            end
`endif
        end
        chk("t1_valid_drop", 32'(rv8), 32'd0);

        // line held high for two windows
        step(1'b1, 1'b0, 1'b0, 1'b1);
        for (int k = 1; k <= 2 * WIN; k++) begin
            step(1'b0, 1'b1, 1'b1, 1'b1);
`ifndef RATE_SMOOTH_EN
            if (k == WIN) chk("t2_first", 32'(rd8), 32'd1);
            if (k == 2 * WIN) chk("t2_second", 32'(rd8), 32'd0);
`endif
        end

        // stalled consumer across two windows
        step(1'b1, 1'b0, 1'b0, 1'b1);
        pulse_window(5, 1'b0);
        pulse_window(7, 1'b0);
`ifndef RATE_SMOOTH_EN
        chk("t4_held", 32'(rd8), 32'd5);
`endif
        chk("t4_overrun", 32'(ov8), 32'd1);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        chk("t4_drain", 32'(rv8), 32'd0);

        // ready coincides with the window-end cycle while full
        step(1'b1, 1'b0, 1'b0, 1'b1);
        pulse_window(3, 1'b0);
        for (int c = 0; c < WIN; c++) begin
            step(1'b0, 1'b1, (c % 2 == 0) && (c / 2 < 4), c == WIN - 1);
        end
        chk("t5_valid", 32'(rv8), 32'd1);
`ifndef RATE_SMOOTH_EN
        chk("t5_data", 32'(rd8), 32'd4);
`endif
        chk("t5_no_overrun", 32'(ov8), 32'd0);

        // freeze mid-window, then reset part-way through a window
        step(1'b1, 1'b0, 1'b0, 1'b1);
        for (int c = 0; c < 5; c++) step(1'b0, 1'b1, c % 2 == 0, 1'b1);
        for (int c = 0; c < 10; c++) step(1'b0, 1'b0, c % 2 == 1, 1'b1);
        for (int c = 0; c < 11; c++) step(1'b0, 1'b1, c % 4 == 1, 1'b1);
        for (int c = 0; c < 9; c++) step(1'b0, 1'b1, c % 2 == 0, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        chk("t6_reset_valid", 32'(rv8), 32'd0);
        for (int c = 0; c < WIN; c++) step(1'b0, 1'b1, (c == 0) || (c == 4), 1'b1);
`ifndef RATE_SMOOTH_EN
        chk("t6_post_reset", 32'(rd8), 32'd2);
`endif

        // randomized traffic
        step(1'b1, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 900; k++) begin
            step($urandom_range(0, 299) == 0,
                 $urandom_range(0, 9) != 0,
                 (k < 450) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 0),
                 $urandom_range(0, 2) != 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
